debounce_scheduler: RTL
=======================

Name: debounce_scheduler

Overview:
- Debounces N_BTN raw push-button inputs with a single shared stability timer instead of one counter per button.
- Channels whose synchronized input disagrees with their clean state request the timer; a round-robin arbiter grants it to one channel at a time.
- Sits between the Basys3 button pins and the LED/control logic. It supplies clean levels plus press, release and bounce event pulses.

Parameters:
- N_BTN, 4, number of button channels (>=1).
- STABLE_TICKS, 1000000, consecutive stable cycles required to commit a change (10 ms at 100 MHz); must be >=2.
- CNT_W, 20, timer width; must satisfy STABLE_TICKS-1 < 2^CNT_W.
- OWN_W, 2, owner index width; set to max(1, clog2(N_BTN)).

Ports:
- CLK  input  1  100 MHz system clock.
- RST_N  input  1  asynchronous active-low reset.
- RAW  input  N_BTN  raw button levels, asynchronous to CLK.
- RAW_SYNC  output  N_BTN  2-flop synchronized RAW.
- CLEAN  output  N_BTN  debounced levels.
- PRESS  output  N_BTN  1-cycle pulse on a committed 0->1 of CLEAN.
- RELEASE  output  N_BTN  1-cycle pulse on a committed 1->0 of CLEAN.
- BOUNCE  output  N_BTN  1-cycle pulse when a timing window aborts.
- BUSY  output  1  high while the timer is owned (state TIMING).
- OWNER  output  OWN_W  index of the current timer owner; 0 when idle.

Behaviour:
- Reset (RST_N low, asynchronous): synchronizers, CLEAN, PRESS, RELEASE, BOUNCE, BUSY, OWNER, timer and rr_ptr all clear to 0; state goes to IDLE. Release is sampled on CLK.
- Synchronizer: RAW -> q1 -> q2 = RAW_SYNC, giving 2 cycles of latency. All decisions use RAW_SYNC only.
- Request: req[i] = RAW_SYNC[i] != CLEAN[i].
- State IDLE:
  - If any req is set, grant the first requesting index at or after rr_ptr, wrapping modulo N_BTN.
  - On the grant edge: OWNER <= grant, cnt <= 0, state <= TIMING, BUSY <= 1.
  - If no req is set, hold.
- State TIMING (owner o), evaluated every cycle in this priority:
  - Abort: if RAW_SYNC[o] == CLEAN[o], then BOUNCE[o] pulses, state <= IDLE, rr_ptr <= (o+1) mod N_BTN. CLEAN is unchanged.
  - Commit: else if cnt == STABLE_TICKS-1, then CLEAN[o] <= RAW_SYNC[o], and PRESS[o] or RELEASE[o] pulses on the same edge. State <= IDLE, rr_ptr <= (o+1) mod N_BTN.
  - Otherwise cnt <= cnt+1.
- On leaving TIMING: BUSY <= 0 and OWNER <= 0.
- Latency for an isolated clean edge on RAW[i] with the timer free: CLEAN[i] changes STABLE_TICKS+3 rising edges after the first edge that samples the new RAW. The breakdown is 2 synchronizer edges, 1 grant edge and STABLE_TICKS timing edges.
- Non-owner channels: may change freely while another channel is timing. Their req is re-evaluated only in IDLE. They never pulse BOUNCE and are never committed without a full window of their own.
- Fairness: IDLE always lasts exactly 1 cycle between windows. The worst-case wait before a grant is (N_BTN-1)*(STABLE_TICKS+1) cycles.
- Pulse outputs:
  - Registered, high for exactly 1 cycle.
  - At most one of PRESS, RELEASE or BOUNCE is high at a time, and only on bit o.
- Reset mid-window: the window is discarded, no pulse is issued, and CLEAN is cleared.
- A request that disappears in IDLE (input reverted before its grant) is simply not granted; it produces no BOUNCE.
- N_BTN=1: rr_ptr is a constant 0 and arbitration degenerates to always granting channel 0.

Test Plan (STABLE_TICKS=8, N_BTN=4, CNT_W=4, OWN_W=2):
- Reset, then RAW=0000 held for 50 cycles -> all outputs 0, BUSY never asserts.
- RAW[1] 0->1 held clean -> BUSY rises with OWNER=1. CLEAN[1] and the PRESS[1] pulse appear 11 edges after RAW is sampled. Later RAW[1]->0 gives a RELEASE[1] pulse at the same latency.
- RAW[2] 0->1, then back to 0 after 5 cycles of TIMING -> BOUNCE[2] pulses once, CLEAN[2] stays 0, state returns to IDLE, the next grant search starts at index 3.
- RAW[0] and RAW[3] rise on the same cycle with rr_ptr=0 -> channel 0 is committed first. Channel 3 is granted after exactly 1 IDLE cycle and commits 9 cycles after channel 0.
- RAW[1] rises, RAW_SYNC[1] has been high for 4 cycles of TIMING, then RST_N is pulsed low asynchronously -> all outputs 0 immediately, and no pulse is issued after release. Since RAW[1] is still high, channel 1 then re-debounces from scratch (CLEAN[1]=1 after another 11 edges).
- All four RAW bits held high continuously -> grants go 0,1,2,3 in order with no starvation. All CLEAN bits are 1 within 4*9+3 cycles, with exactly one PRESS pulse per bit.

Source files
------------

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: debounces N_BTN buttons with one stability timer shared round-robin
// Ports:
//   clk, rst_n        - system clock, asynchronous active-low reset
//   raw               - raw button levels (asynchronous)
//   raw_sync          - 2-flop synchronized raw
//   clean             - debounced levels
//   press, released   - 1-cycle pulses on committed rise / fall of clean
//   bounce            - 1-cycle pulse when the owner's window aborts
//   busy, owner       - timer owned flag and owning channel (0 when idle)
module debounce_scheduler #(
  parameter int N_BTN        = 4,
  parameter int STABLE_TICKS = 1000000,
  parameter int CNT_W        = 20,
  parameter int OWN_W        = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] raw,
  output logic [N_BTN-1:0] raw_sync,
  output logic [N_BTN-1:0] clean,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] released,
  output logic [N_BTN-1:0] bounce,
  output logic             busy,
  output logic [OWN_W-1:0] owner
);
  typedef enum logic {IDLE, TIMING} state_t;
  state_t state, state_nx;
  logic [N_BTN-1:0] q1, req, clean_nx, press_nx, rel_nx, bounce_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [OWN_W-1:0] rr_ptr, rr_nx, owner_nx, grant, nxt_ptr;
  logic             busy_nx, stay, done;
  int               idx;
  assign req     = raw_sync ^ clean;
  assign stay    = raw_sync[owner] == clean[owner];
  assign done    = cnt == CNT_W'(STABLE_TICKS - 1);
  assign nxt_ptr = (int'(owner) == N_BTN - 1) ? '0 : owner + 1'b1;
  // first requester at or after rr_ptr: scan downward so the smallest offset wins
  always_comb begin
    grant = '0;
    idx   = 0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_BTN;
      if (req[idx]) grant = OWN_W'(idx);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q1       <= '0;
      raw_sync <= '0;
      state    <= IDLE;
      cnt      <= '0;
      rr_ptr   <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      clean    <= '0;
      press    <= '0;
      released <= '0;
      bounce   <= '0;
    end else begin
      q1       <= raw;
      raw_sync <= q1;
      state    <= state_nx;
      cnt      <= cnt_nx;
      rr_ptr   <= rr_nx;
      owner    <= owner_nx;
      busy     <= busy_nx;
      clean    <= clean_nx;
      press    <= press_nx;
      released <= rel_nx;
      bounce   <= bounce_nx;
    end
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = |req ? TIMING : IDLE;
    else if (stay || done) state_nx = IDLE;
  end
  // abort takes priority over commit, so a window that ends on the same cycle the input reverts still bounces
  always_comb begin
    cnt_nx    = cnt;
    rr_nx     = rr_ptr;
    owner_nx  = owner;
    busy_nx   = busy;
    clean_nx  = clean;
    press_nx  = '0;
    rel_nx    = '0;
    bounce_nx = '0;
    if (state == IDLE) begin
      if (|req) begin
        owner_nx = grant;
        cnt_nx   = '0;
        busy_nx  = 1'b1;
      end
    end else if (stay || done) begin
      busy_nx  = 1'b0;
      owner_nx = '0;
      rr_nx    = nxt_ptr;
      if (stay) bounce_nx[owner] = 1'b1;
      else begin
        clean_nx[owner] = raw_sync[owner];
        press_nx[owner] = raw_sync[owner];
        rel_nx[owner]   = ~raw_sync[owner];
      end
    end else cnt_nx = cnt + 1'b1;
  end
endmodule
